// File: rtl/uop_queue_pkg.sv
// Shared types for the micro-op queue: uop payload and flag+value ring pointers.
package uop_queue_pkg;

   localparam int unsigned PC_W      = 32;
   localparam int unsigned OP_W      = 8;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned IMM_W     = 32;
   localparam int unsigned MAX_PTR_W = 16;
   localparam int unsigned CNT_W     = MAX_PTR_W + 1;

   // Decoded micro-op as handed from decode to issue.
   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [OP_W-1:0]  opcode;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm;
   } uop_info_t;

   localparam int unsigned UOP_W = $bits(uop_info_t);

   // Ring pointer: value indexes storage, flag toggles on every wrap so that
   // equal values can be told apart as empty (flags equal) or full (flags differ).
   // The value field is sized for the largest supported depth; unused high bits stay 0.
   typedef struct packed {
      logic                 flag;
      logic [MAX_PTR_W-1:0] value;
   } circ_ptr_t;

   // Advance a pointer by one slot in a ring of 'depth' entries.
   function automatic circ_ptr_t ptr_incr(input circ_ptr_t p, input int unsigned depth);
      circ_ptr_t n;
      n = p;
      if (32'(p.value) == depth - 1) begin
         n.value = '0;
         n.flag  = ~p.flag;
      end else begin
         n.value = p.value + MAX_PTR_W'(1);
      end
      return n;
   endfunction

   function automatic logic ptr_empty(input circ_ptr_t head, input circ_ptr_t tail);
      return head == tail;
   endfunction

   function automatic logic ptr_full(input circ_ptr_t head, input circ_ptr_t tail);
      return (head.flag != tail.flag) && (head.value == tail.value);
   endfunction

   // Occupancy; a differing flag means the tail has lapped the head once.
   function automatic logic [CNT_W-1:0] ptr_count(input circ_ptr_t head, input circ_ptr_t tail,
                                                  input int unsigned depth);
      logic [CNT_W-1:0] span;
      span = (head.flag != tail.flag) ? CNT_W'(depth) : '0;
      return span + {1'b0, tail.value} - {1'b0, head.value};
   endfunction

endpackage

// File: rtl/uop_queue_circ_ptr.sv
// Flag+value ring pointer register with increment and synchronous clear.
module circ_ptr
   import uop_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      inc_i,
   input  logic      clr_i,
   output circ_ptr_t ptr_o
);

   // Depth must be a power of two that the pointer struct can hold.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > 2**MAX_PTR_W) begin : g_bad_depth
      $error("circ_ptr: DEPTH must be a power of two between 2 and 2**MAX_PTR_W");
   end

   // Pointer state; clear wins over increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_o <= '0;
      end else if (clr_i) begin
         ptr_o <= '0;
      end else if (inc_i) begin
         ptr_o <= ptr_incr(ptr_o, DEPTH);
      end
   end

endmodule

// File: rtl/uop_queue.sv
// Circular micro-op buffer between decode and issue with valid/ready on both sides.
module uop_queue
   import uop_queue_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             enq_valid_i,
   output logic             enq_ready_o,
   input  logic [UOP_W-1:0] enq_uop_i,
   output logic             deq_valid_o,
   input  logic             deq_ready_i,
   output logic [UOP_W-1:0] deq_uop_o,
   output logic [PTR_W:0]   count_o,
   output logic             full_o,
   output logic             empty_o
);

   circ_ptr_t        head_q;
   circ_ptr_t        tail_q;
   logic             full;
   logic             empty;
   logic             enq_fire;
   logic             deq_fire;
   logic [UOP_W-1:0] mem [DEPTH];

   // Status is derived from the registered pointers only, so reset clears it at once.
   assign empty       = ptr_empty(head_q, tail_q);
   assign full        = ptr_full(head_q, tail_q);
   assign count_o     = (PTR_W + 1)'(ptr_count(head_q, tail_q, DEPTH));
   assign full_o      = full;
   assign empty_o     = empty;
   assign enq_ready_o = ~full;
   assign deq_valid_o = ~empty;

   // A full queue refuses enqueue even if the head is leaving this cycle.
   assign enq_fire = enq_valid_i & ~full;
   assign deq_fire = deq_ready_i & ~empty;

   circ_ptr #(.DEPTH(DEPTH)) u_head (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (deq_fire),
      .clr_i  (flush_i),
      .ptr_o  (head_q)
   );

   circ_ptr #(.DEPTH(DEPTH)) u_tail (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (enq_fire),
      .clr_i  (flush_i),
      .ptr_o  (tail_q)
   );

   // Payload storage; not reset, a flush drops the write.
   always_ff @(posedge clk_i) begin
      if (enq_fire && !flush_i) begin
         mem[tail_q.value[PTR_W-1:0]] <= enq_uop_i;
      end
   end

   assign deq_uop_o = mem[head_q.value[PTR_W-1:0]];

   // Producer must hold a refused request until it is taken.
   a_enq_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (enq_valid_i && !enq_ready_o && !flush_i) |=> enq_valid_i);

   a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_o <= (PTR_W + 1)'(DEPTH));

   a_no_enq_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      enq_fire |-> !full);

   a_no_deq_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      deq_fire |-> !empty);

endmodule

// File: tb/tb_uop_queue.sv
// Directed bench for uop_queue (DEPTH=4) against a queue-based reference model.
module tb_uop_queue;
   import uop_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic             clk = 1'b0;
   logic             rst_ni = 1'b1;
   logic             flush_i = 1'b0;
   logic             enq_valid_i = 1'b0;
   logic             enq_ready_o;
   uop_info_t        enq_uop_i = '0;
   logic             deq_valid_o;
   logic             deq_ready_i = 1'b0;
   logic [UOP_W-1:0] deq_uop_o;
   logic [CW-1:0]    count_o;
   logic             full_o;
   logic             empty_o;

   uop_info_t   model_q[$];
   int unsigned nvec = 0;
   int unsigned nerr = 0;
   bit          chk_en = 1'b0;

   uop_queue #(.DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .enq_valid_i (enq_valid_i),
      .enq_ready_o (enq_ready_o),
      .enq_uop_i   (enq_uop_i),
      .deq_valid_o (deq_valid_o),
      .deq_ready_i (deq_ready_i),
      .deq_uop_o   (deq_uop_o),
      .count_o     (count_o),
      .full_o      (full_o),
      .empty_o     (empty_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic uop_info_t mk(input logic [31:0] pc);
      uop_info_t u;
      u.pc     = pc;
      u.opcode = pc[7:0] ^ 8'h5A;
      u.rd     = pc[6:2];
      u.rs1    = pc[10:6];
      u.rs2    = pc[4:0] ^ 5'h13;
      u.imm    = ~pc;
      return u;
   endfunction

   function automatic logic [31:0] head_pc();
      uop_info_t d;
      d = deq_uop_o;
      return d.pc;
   endfunction

   // Reference model: a plain FIFO advanced with the handshake rules.
   always @(posedge clk) begin
      int n;
      bit do_enq;
      bit do_deq;
      if (!rst_ni || flush_i) begin
         model_q.delete();
      end else begin
         n      = model_q.size();
         do_enq = enq_valid_i && (n < DEPTH);
         do_deq = deq_ready_i && (n > 0);
         if (do_deq) void'(model_q.pop_front());
         if (do_enq) model_q.push_back(enq_uop_i);
      end
   end

   // Every cycle: DUT status and head payload versus the model.
   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = model_q.size();
         check("count", 128'(count_o), 128'(n));
         check("empty", 128'(empty_o), 128'(n == 0));
         check("full", 128'(full_o), 128'(n == DEPTH));
         check("enq_ready", 128'(enq_ready_o), 128'(n != DEPTH));
         check("deq_valid", 128'(deq_valid_o), 128'(n != 0));
         if (n > 0) check("deq_uop", 128'(deq_uop_o), 128'(model_q[0]));
      end
   end

   task automatic drive(input bit ev, input logic [31:0] pc, input bit dr, input bit fl);
      enq_valid_i = ev;
      enq_uop_i   = mk(pc);
      deq_ready_i = dr;
      flush_i     = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc [5];
      int ei;
      int di;
      bit ev;
      bit dr;
      exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

      // reset then idle
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_ni = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_empty", 128'(empty_o), 128'(1));
      check("rst_full", 128'(full_o), 128'(0));
      check("rst_count", 128'(count_o), 128'(0));
      check("rst_enq_ready", 128'(enq_ready_o), 128'(1));
      check("rst_deq_valid", 128'(deq_valid_o), 128'(0));

      // fill to full; a fifth request is held off
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      check("fill_count", 128'(count_o), 128'(4));
      check("fill_full", 128'(full_o), 128'(1));
      check("fill_enq_ready", 128'(enq_ready_o), 128'(0));
      drive(1'b1, 32'h110, 1'b0, 1'b0);
      check("held_count", 128'(count_o), 128'(4));

      // drain; the held request enters once a slot opens
      check("drain_pc0", 128'(head_pc()), 128'(exp_pc[0]));
      drive(1'b1, 32'h110, 1'b1, 1'b0);
      check("full_deq_count", 128'(count_o), 128'(3));
      check("full_deq_ready", 128'(enq_ready_o), 128'(1));
      check("drain_pc1", 128'(head_pc()), 128'(exp_pc[1]));
      drive(1'b1, 32'h110, 1'b1, 1'b0);
      check("both_fire_count", 128'(count_o), 128'(3));
      for (int k = 2; k < 5; k++) begin
         check("drain_pc", 128'(head_pc()), 128'(exp_pc[k]));
         drive(1'b0, 32'h0, 1'b1, 1'b0);
      end
      check("drain_empty", 128'(empty_o), 128'(1));

      // interleaved traffic across the index wrap, occupancy at most 2
      ei = 0;
      di = 0;
      for (int c = 0; c < 8; c++) begin
         ev = (c < 6);
         dr = (c >= 2);
         if (dr) check("wrap_pc", 128'(head_pc()), 128'(32'h200 + 32'(4 * di)));
         drive(ev, 32'h200 + 32'(4 * ei), dr, 1'b0);
         ei += int'(ev);
         di += int'(dr);
         check("wrap_count_le2", 128'(count_o <= 3'd2), 128'(1));
      end
      check("wrap_empty", 128'(empty_o), 128'(1));

      // flush beats a simultaneous enq and deq
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      drive(1'b1, 32'h304, 1'b0, 1'b0);
      check("pre_flush_count", 128'(count_o), 128'(2));
      drive(1'b1, 32'hDEA0, 1'b1, 1'b1);
      check("flush_count", 128'(count_o), 128'(0));
      check("flush_empty", 128'(empty_o), 128'(1));
      drive(1'b1, 32'h308, 1'b0, 1'b0);
      check("post_flush_pc", 128'(head_pc()), 128'(32'h308));
      check("post_flush_count", 128'(count_o), 128'(1));
      drive(1'b0, 32'h0, 1'b1, 1'b0);

      // asynchronous reset between edges with three entries queued
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      check("pre_rst_count", 128'(count_o), 128'(3));
      enq_valid_i = 1'b0;
      #2 rst_ni = 1'b0;
      model_q.delete();
      #1;
      check("async_rst_count", 128'(count_o), 128'(0));
      check("async_rst_deq_valid", 128'(deq_valid_o), 128'(0));
      check("async_rst_empty", 128'(empty_o), 128'(1));
      @(negedge clk);
      #2 rst_ni = 1'b1;
      @(negedge clk);

      // recovery after reset
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      check("recover_pc", 128'(head_pc()), 128'(32'h500));
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check("recover_empty", 128'(empty_o), 128'(1));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Parametrised circular buffer of decoded micro-ops (liang_pkg::uop_info_t), placed between decode and issue.
- Occupancy is tracked with flag+value head/tail pointers, a generalisation of the 1-bit utils ptr_t to an arbitrary index width.
- Valid/ready handshake on both sides, synchronous flush for redirects, and occupancy/status outputs for back-pressure and debug.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2 (elaboration error otherwise).
- PTR_W, $clog2(DEPTH), index width of pointer value field; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; empties queue next cycle.
- enq_valid_i  in  1  enqueue request.
- enq_ready_o  out  1  queue can accept (= !full).
- enq_uop_i  in  $bits(uop_info_t)  uop to enqueue.
- deq_valid_o  out  1  head entry valid (= !empty).
- deq_ready_i  in  1  consumer accepts head.
- deq_uop_o  out  $bits(uop_info_t)  head entry payload.
- count_o  out  PTR_W+1  current occupancy, 0..DEPTH.
- full_o  out  1  occupancy == DEPTH.
- empty_o  out  1  occupancy == 0.

Behaviour:
- State: storage array mem[DEPTH]; head_q, tail_q, each {flag, value[PTR_W-1:0]}.
- Reset (rst_ni low, asynchronous): head_q = tail_q = {0,0}.
  - Outputs after reset: enq_ready_o=1, deq_valid_o=0, count_o=0, full_o=0, empty_o=1.
  - mem is not reset; deq_uop_o is don't-care while empty.
- Status, combinational from registered pointers only:
  - empty = head==tail (flag and value).
  - full = flags differ and values equal.
  - count = {tail.flag^head.flag, tail.value} - {1'b0, head.value}, computed modulo 2^(PTR_W+1).
- Enqueue fire = enq_valid_i & enq_ready_o.
  - Write enq_uop_i to mem[tail.value].
  - Increment tail: value wraps DEPTH-1→0 and toggles flag on wrap.
- Dequeue fire = deq_valid_o & deq_ready_i.
  - Increment head with the same wrap rule.
  - deq_uop_o = mem[head.value], combinational read.
- Latency: an entry enqueued at edge N is visible on deq_valid_o/deq_uop_o after edge N. There is no same-cycle bypass when empty.
- enq_ready_o depends only on state, never on deq_ready_i.
  - When full, simultaneous deq+enq is not allowed; only the deq fires, and the next cycle shows count=DEPTH-1, enq_ready_o=1.
- Simultaneous enq and deq when neither full nor empty: both fire, count unchanged.
- flush_i has priority over enq/deq in the same cycle.
  - Next state head=tail={0,0}; the enq write is suppressed and no entry is considered dequeued.
  - Outputs still reflect the pre-flush state during the flush cycle; consumers must ignore deq handshakes while flush_i=1.
- Reset asserted mid-operation: pointers clear immediately (async), all in-flight contents are discarded.
- Protocol assertions (sim-only):
  - enq_valid_i stays high until ready.
  - count_o ≤ DEPTH.
  - Never enqueue when full, never dequeue when empty.

Decomposition:
- utils package, extended:
  - Parametrised pointer struct circ_ptr_t (flag + PTR_W-bit value), via a parametrised class typedef or a fixed-max-width struct.
  - Functions ptr_incr, ptr_empty, ptr_full, ptr_count.
  - Also fixes the missing semicolon on the package header.
- liang_pkg is unchanged; it supplies uop_info_t.
- One sub-module: circ_ptr.
  - Pointer register with async active-low reset, inc_i, clr_i (flush), DEPTH parameter.
  - Instantiated twice, for head and tail.

Test Plan (DEPTH=4):
- Reset then idle → empty_o=1, full_o=0, count_o=0, enq_ready_o=1, deq_valid_o=0.
- Enqueue pc=0x100,0x104,0x108,0x10C on 4 consecutive cycles, deq_ready_i=0 → full_o=1, count_o=4, enq_ready_o=0; 5th enq_valid_i held is not accepted.
- From full, deq_ready_i=1 for 4 cycles → deq_uop_o.pc = 0x100,0x104,0x108,0x10C in order, then empty_o=1; head.flag toggled to 1.
- Wrap: 6 enq then 6 deq interleaved with count ≤2 → FIFO order preserved across index 3→0, flags toggle, count_o never exceeds 2.
- With count=2, assert enq_valid_i, deq_ready_i and flush_i together → next cycle count_o=0, empty_o=1; the flushed enq payload never appears at deq_uop_o.
- With count=3, drop rst_ni between clock edges → count_o=0 and deq_valid_o=0 immediately, before the next edge.
